// File: rtl/singularis_alu_pkg.sv
// Shared opcode and instruction-class definitions for the Singularis 16-bit processor.
// The ALU, branch unit and display logic all decode against these constants.
package singularis_alu_pkg;

    localparam int ALU_WIDTH = 16;

    localparam logic [1:0] TYPE_ALU_REG = 2'b00;
    localparam logic [1:0] TYPE_ALU_IMM = 2'b01;
    localparam logic [1:0] TYPE_JMP     = 2'b10;
    localparam logic [1:0] TYPE_SYS     = 2'b11;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_XOR = 5'b00111;
    localparam logic [4:0] OP_NOT = 5'b01000;
    localparam logic [4:0] OP_SHL = 5'b01001;
    localparam logic [4:0] OP_SHR = 5'b01010;
    localparam logic [4:0] OP_INC = 5'b01011;
    localparam logic [4:0] OP_DEC = 5'b01100;
    localparam logic [4:0] OP_MUL = 5'b01101;
    localparam logic [4:0] OP_EQ  = 5'b01110;
    localparam logic [4:0] OP_LT  = 5'b01111;
    localparam logic [4:0] OP_GT  = 5'b10000;
    localparam logic [4:0] OP_MOV = 5'b10001;

    // Jump and display opcodes, decoded by the branch and display blocks.
    localparam logic [4:0] OP_JMP  = 5'b10100;
    localparam logic [4:0] OP_JZ   = 5'b10101;
    localparam logic [4:0] OP_JC   = 5'b10110;
    localparam logic [4:0] OP_JB   = 5'b10111;
    localparam logic [4:0] OP_DISP = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    function automatic logic is_alu_type(input logic [1:0] t);
        return (t == TYPE_ALU_REG) || (t == TYPE_ALU_IMM);
    endfunction

endpackage

// File: rtl/singularis_alu_core.sv
// Combinational ALU datapath: result, carry/overflow, compare bit and a decode of
// which architectural state (accumulator group or bool) the opcode is allowed to write.
module singularis_alu_core
    import singularis_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             cmp,
    output logic             writes_acc,
    output logic             writes_bool
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0]   rhs_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     diff_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH:0]     shl_s;
    logic [WIDTH:0]     shr_s;
    logic [SW-1:0]      shamt_s;
    logic               add_ovf_s;
    logic               sub_ovf_s;

    assign rhs_s   = ((opcode == OP_INC) || (opcode == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign sum_s   = {1'b0, a} + {1'b0, rhs_s};
    // The extra MSB of an unsigned (W+1)-bit difference is exactly the borrow.
    assign diff_s  = {1'b0, a} - {1'b0, rhs_s};
    assign prod_s  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign shamt_s = b[SW-1:0];
    // One guard bit on the far side of each shift catches the last bit shifted out.
    assign shl_s   = {1'b0, a} << shamt_s;
    assign shr_s   = {a, 1'b0} >> shamt_s;

    assign add_ovf_s = (a[WIDTH-1] == rhs_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf_s = (a[WIDTH-1] != rhs_s[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);

    // Opcode decode and result selection.
    always_comb begin
        result      = {WIDTH{1'b0}};
        carry       = 1'b0;
        overflow    = 1'b0;
        cmp         = 1'b0;
        writes_acc  = 1'b0;
        writes_bool = 1'b0;
        case (opcode)
            OP_ADD, OP_INC: begin
                result     = sum_s[WIDTH-1:0];
                carry      = sum_s[WIDTH];
                overflow   = add_ovf_s;
                writes_acc = 1'b1;
            end
            OP_SUB, OP_DEC: begin
                result     = diff_s[WIDTH-1:0];
                carry      = diff_s[WIDTH];
                overflow   = sub_ovf_s;
                writes_acc = 1'b1;
            end
            OP_AND: begin
                result     = a & b;
                writes_acc = 1'b1;
            end
            OP_OR: begin
                result     = a | b;
                writes_acc = 1'b1;
            end
            OP_XOR: begin
                result     = a ^ b;
                writes_acc = 1'b1;
            end
            OP_NOT: begin
                result     = ~a;
                writes_acc = 1'b1;
            end
            OP_SHL: begin
                result     = shl_s[WIDTH-1:0];
                carry      = shl_s[WIDTH];
                writes_acc = 1'b1;
            end
            OP_SHR: begin
                result     = shr_s[WIDTH:1];
                carry      = shr_s[0];
                writes_acc = 1'b1;
            end
            OP_MUL: begin
                result     = prod_s[WIDTH-1:0];
                carry      = |prod_s[2*WIDTH-1:WIDTH];
                overflow   = |prod_s[2*WIDTH-1:WIDTH];
                writes_acc = 1'b1;
            end
            OP_EQ: begin
                cmp         = (a == b);
                writes_bool = 1'b1;
            end
            OP_LT: begin
                cmp         = (a < b);
                writes_bool = 1'b1;
            end
            OP_GT: begin
                cmp         = (a > b);
                writes_bool = 1'b1;
            end
            OP_MOV: begin
                result     = a;
                writes_acc = 1'b1;
            end
            default: begin
                result      = {WIDTH{1'b0}};
                writes_acc  = 1'b0;
                writes_bool = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/singularis_alu.sv
// Registered Singularis ALU: accumulator plus carry/overflow/bool/zero flags,
// updated from the combinational core only for enabled ALU-class instructions.
module singularis_alu
    import singularis_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [1:0]       instr_type,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       opcode,
    output logic [WIDTH-1:0] accumulator,
    output logic             carry,
    output logic             overflow,
    output logic             bool,
    output logic             zero
);

    logic [WIDTH-1:0] core_result_s;
    logic             core_carry_s;
    logic             core_overflow_s;
    logic             core_cmp_s;
    logic             core_writes_acc_s;
    logic             core_writes_bool_s;
    logic             update_s;

    logic [WIDTH-1:0] acc_d, acc_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             bool_d, bool_q;
    logic             zero_d, zero_q;

    singularis_alu_core #(.WIDTH(WIDTH)) u_core (
        .opcode      (opcode),
        .a           (a),
        .b           (b),
        .result      (core_result_s),
        .carry       (core_carry_s),
        .overflow    (core_overflow_s),
        .cmp         (core_cmp_s),
        .writes_acc  (core_writes_acc_s),
        .writes_bool (core_writes_bool_s)
    );

    assign update_s = clk_enable && is_alu_type(instr_type);

    // Next-state selection: the accumulator group and bool update independently.
    always_comb begin
        acc_d      = acc_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        bool_d     = bool_q;
        zero_d     = zero_q;
        if (update_s && core_writes_acc_s) begin
            acc_d      = core_result_s;
            carry_d    = core_carry_s;
            overflow_d = core_overflow_s;
            zero_d     = (core_result_s == {WIDTH{1'b0}});
        end else begin
            acc_d = acc_q;
        end
        if (update_s && core_writes_bool_s) begin
            bool_d = core_cmp_s;
        end else begin
            bool_d = bool_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= {WIDTH{1'b0}};
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            bool_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            bool_q     <= bool_d;
            zero_q     <= zero_d;
        end
    end

    assign accumulator = acc_q;
    assign carry       = carry_q;
    assign overflow    = overflow_q;
    assign bool        = bool_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_singularis_alu.sv
// Scoreboard bench for singularis_alu: a behavioural reference model queues the
// expected register state for every issued instruction and the monitor pops it.
module tb_singularis_alu;

    localparam logic [4:0] T_ADD = 5'b00011, T_SUB = 5'b00100, T_AND = 5'b00101;
    localparam logic [4:0] T_OR  = 5'b00110, T_XOR = 5'b00111, T_NOT = 5'b01000;
    localparam logic [4:0] T_SHL = 5'b01001, T_SHR = 5'b01010, T_INC = 5'b01011;
    localparam logic [4:0] T_DEC = 5'b01100, T_MUL = 5'b01101, T_EQ  = 5'b01110;
    localparam logic [4:0] T_LT  = 5'b01111, T_GT  = 5'b10000, T_MOV = 5'b10001;

    typedef struct packed {
        logic [15:0] acc;
        logic        c;
        logic        v;
        logic        bo;
        logic        z;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [1:0]  instr_type;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  opcode;
    logic [15:0] accumulator;
    logic        carry;
    logic        overflow;
    logic        bool;
    logic        zero;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb_q[$];

    logic [15:0] m_acc;
    logic        m_c, m_v, m_bo, m_z;

    singularis_alu dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .instr_type  (instr_type),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .accumulator (accumulator),
        .carry       (carry),
        .overflow    (overflow),
        .bool        (bool),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 16'h0000;
        m_c   = 1'b0;
        m_v   = 1'b0;
        m_bo  = 1'b0;
        m_z   = 1'b0;
    endtask

    task automatic model_step(input logic [1:0] t, input logic [4:0] op,
                              input logic [15:0] ma, input logic [15:0] mb, input logic en);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] rb;
        logic        wr;
        int          n;
        if (!en || t[1]) return;
        wr = 1'b1;
        n  = int'(mb[3:0]);
        rb = (op == T_INC || op == T_DEC) ? 16'h0001 : mb;
        case (op)
            T_ADD, T_INC: begin
                w = {1'b0, ma} + {1'b0, rb};
                m_acc = w[15:0]; m_c = w[16];
                m_v = (ma[15] == rb[15]) && (w[15] != ma[15]);
            end
            T_SUB, T_DEC: begin
                m_acc = ma - rb; m_c = (ma < rb);
                m_v = (ma[15] != rb[15]) && (m_acc[15] != ma[15]);
            end
            T_AND: begin m_acc = ma & mb; m_c = 1'b0; m_v = 1'b0; end
            T_OR:  begin m_acc = ma | mb; m_c = 1'b0; m_v = 1'b0; end
            T_XOR: begin m_acc = ma ^ mb; m_c = 1'b0; m_v = 1'b0; end
            T_NOT: begin m_acc = ~ma;     m_c = 1'b0; m_v = 1'b0; end
            T_MOV: begin m_acc = ma;      m_c = 1'b0; m_v = 1'b0; end
            T_SHL: begin
                m_acc = ma << n; m_v = 1'b0;
                m_c = (n == 0) ? 1'b0 : ma[16-n];
            end
            T_SHR: begin
                m_acc = ma >> n; m_v = 1'b0;
                m_c = (n == 0) ? 1'b0 : ma[n-1];
            end
            T_MUL: begin
                p = ma * mb;
                m_acc = p[15:0]; m_c = (p[31:16] != 16'h0000); m_v = m_c;
            end
            T_EQ: begin m_bo = (ma == mb); wr = 1'b0; end
            T_LT: begin m_bo = (ma < mb);  wr = 1'b0; end
            T_GT: begin m_bo = (ma > mb);  wr = 1'b0; end
            default: wr = 1'b0;
        endcase
        if (wr) m_z = (m_acc == 16'h0000);
    endtask

    task automatic do_op(input string tag, input logic [1:0] t, input logic [4:0] op,
                         input logic [15:0] ta, input logic [15:0] tb, input logic en);
        exp_t e;
        @(negedge clk);
        instr_type = t; opcode = op; a = ta; b = tb; clk_enable = en;
        model_step(t, op, ta, tb, en);
        sb_q.push_back('{m_acc, m_c, m_v, m_bo, m_z});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val({tag, "_acc"},  {16'h0, accumulator}, {16'h0, e.acc});
        check_val({tag, "_carry"}, {31'h0, carry},     {31'h0, e.c});
        check_val({tag, "_ovf"},   {31'h0, overflow},  {31'h0, e.v});
        check_val({tag, "_bool"},  {31'h0, bool},      {31'h0, e.bo});
        check_val({tag, "_zero"},  {31'h0, zero},      {31'h0, e.z});
    endtask

    task automatic check_all_clear(input string tag);
        check_val({tag, "_acc"},   {16'h0, accumulator}, 32'h0);
        check_val({tag, "_flags"}, {28'h0, carry, overflow, bool, zero}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; clk_enable = 1'b0; instr_type = 2'b00;
        a = 16'h0000; b = 16'h0000; opcode = 5'b00000;
        model_reset();
        #2;
        check_all_clear("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Asynchronous reset in the middle of a live sequence.
        do_op("mov1234", 2'b00, T_MOV, 16'h1234, 16'h0000, 1'b1);
        check_val("mov1234_const", {16'h0, accumulator}, 32'h1234);
        @(negedge clk);
        instr_type = 2'b00; opcode = T_ADD; a = 16'h0001; b = 16'h0001; clk_enable = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_all_clear("async_rst");
        @(posedge clk);
        #1;
        check_all_clear("rst_held");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        do_op("add_2_3", 2'b00, T_ADD, 16'h0002, 16'h0003, 1'b1);
        check_val("add_2_3_const", {16'h0, accumulator}, 32'h0005);

        do_op("add_wrap", 2'b00, T_ADD, 16'hFFFF, 16'h0001, 1'b1);
        check_val("add_wrap_const", {16'h0, accumulator, carry, zero}, {16'h0, 16'h0000, 1'b1, 1'b1});
        do_op("add_ovf", 2'b00, T_ADD, 16'h7FFF, 16'h0001, 1'b1);
        check_val("add_ovf_const", {15'h0, accumulator, overflow}, {15'h0, 16'h8000, 1'b1});
        do_op("sub_borrow", 2'b01, T_SUB, 16'h0003, 16'h0005, 1'b1);
        check_val("sub_borrow_const", {15'h0, accumulator, carry}, {15'h0, 16'hFFFE, 1'b1});
        do_op("sub_ovf", 2'b01, T_SUB, 16'h8000, 16'h0001, 1'b1);
        check_val("sub_ovf_const", {15'h0, accumulator, overflow}, {15'h0, 16'h7FFF, 1'b1});
        do_op("sub_0_1", 2'b00, T_SUB, 16'h0000, 16'h0001, 1'b1);

        do_op("mov_aa", 2'b00, T_MOV, 16'h00AA, 16'h0000, 1'b1);
        do_op("eq_7_7", 2'b00, T_EQ, 16'h0007, 16'h0007, 1'b1);
        check_val("eq_hold_const", {15'h0, accumulator, bool}, {15'h0, 16'h00AA, 1'b1});
        do_op("lt_9_4", 2'b00, T_LT, 16'h0009, 16'h0004, 1'b1);
        do_op("gt_9_4", 2'b01, T_GT, 16'h0009, 16'h0004, 1'b1);

        do_op("gate_en", 2'b00, T_ADD, 16'h0001, 16'h0001, 1'b0);
        do_op("gate_jmp", 2'b10, T_ADD, 16'h0001, 16'h0001, 1'b1);
        do_op("gate_sys", 2'b11, T_ADD, 16'h0001, 16'h0001, 1'b1);
        do_op("gate_op31", 2'b00, 5'b11111, 16'h0001, 16'h0001, 1'b1);
        do_op("gate_op0", 2'b00, 5'b00000, 16'h0001, 16'h0001, 1'b1);
        check_val("gate_const", {16'h0, accumulator}, 32'h00AA);

        do_op("shl_8001", 2'b00, T_SHL, 16'h8001, 16'h0001, 1'b1);
        check_val("shl_const", {15'h0, accumulator, carry}, {15'h0, 16'h0002, 1'b1});
        do_op("shl_0", 2'b00, T_SHL, 16'hFFFF, 16'h0010, 1'b1);
        do_op("shr_4a", 2'b00, T_SHR, 16'h8001, 16'h0004, 1'b1);
        do_op("shr_4b", 2'b00, T_SHR, 16'h000F, 16'h0004, 1'b1);
        do_op("shr_15", 2'b00, T_SHR, 16'h8000, 16'h000F, 1'b1);
        do_op("mul_ovf", 2'b00, T_MUL, 16'h0100, 16'h0100, 1'b1);
        check_val("mul_const", {14'h0, accumulator, carry, zero}, {14'h0, 16'h0000, 1'b1, 1'b1});
        do_op("mul_small", 2'b01, T_MUL, 16'h0012, 16'h0034, 1'b1);
        do_op("inc_wrap", 2'b00, T_INC, 16'hFFFF, 16'h1234, 1'b1);
        do_op("inc_ovf", 2'b00, T_INC, 16'h7FFF, 16'h0000, 1'b1);
        do_op("dec_0", 2'b00, T_DEC, 16'h0000, 16'h5555, 1'b1);
        do_op("dec_8000", 2'b00, T_DEC, 16'h8000, 16'h0000, 1'b1);
        do_op("and", 2'b00, T_AND, 16'hF0F0, 16'h0FF0, 1'b1);
        do_op("or", 2'b00, T_OR, 16'hF000, 16'h000F, 1'b1);
        do_op("xor", 2'b00, T_XOR, 16'hAAAA, 16'hAAAA, 1'b1);
        do_op("not", 2'b00, T_NOT, 16'h00FF, 16'h0000, 1'b1);

        for (int i = 0; i < 80; i++) begin
            do_op("rand", 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  16'($urandom), 16'($urandom), ($urandom_range(0, 7) != 0));
        end

        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
